// File: rtl/execute_muldiv.sv
// RV32M multiply/divide unit for the execute stage: shift-add multiply and restoring divide on operand magnitudes.
// Optional macro MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle 64-bit product.
module execute_muldiv #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  e_start,
  input  logic [2:0]            e_mdop,
  input  logic [DATA_WIDTH-1:0] e_rd1,
  input  logic [DATA_WIDTH-1:0] e_rd2,
  input  logic [4:0]            e_rd,
  input  logic                  e_flush,
  output logic                  md_stall,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [DATA_WIDTH-1:0] md_result,
  output logic [4:0]            md_rd
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } md_op_t;

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                    state_q, state_d;
  md_op_t                    op_in, op_q;
  logic [DATA_WIDTH-1:0]     ma_q, mb_q;
  logic                      neg_q, rneg_q;
  logic [2*DATA_WIDTH-1:0]   acc_q, acc_nx;
  logic [4:0]                cnt_q, rd_q;

  logic                      accept, is_div_in, a_sgn, b_sgn, sa, sb;
  logic                      div_zero, div_ovf, short_path, last_iter;
  logic [DATA_WIDTH-1:0]     a_mag, b_mag, short_val, final_val;
  logic [DATA_WIDTH:0]       mul_sum, div_diff;
  logic [2*DATA_WIDTH:0]     div_sh;
  logic [2*DATA_WIDTH-1:0]   mul_signed;
  logic [DATA_WIDTH-1:0]     quo_signed, rem_signed;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_WIDTH-1:0]   fast_prod, fast_signed;
`endif

  // Operand decode and magnitude conversion at acceptance
  always_comb begin
    op_in     = md_op_t'(e_mdop);
    is_div_in = e_mdop[2];
    a_sgn     = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
    b_sgn     = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    sa        = a_sgn & e_rd1[DATA_WIDTH-1];
    sb        = b_sgn & e_rd2[DATA_WIDTH-1];
    a_mag     = sa ? -e_rd1 : e_rd1;
    b_mag     = sb ? -e_rd2 : e_rd2;
    div_zero  = is_div_in && (e_rd2 == '0);
    div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) && (e_rd1 == MIN_NEG) && (e_rd2 == '1);
    accept    = ((state_q == IDLE) || (state_q == DONE)) && e_start && !e_flush;
  end

  always_comb begin
    short_path = div_zero || div_ovf;
    short_val  = '0;
    if (div_zero)
      short_val = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : e_rd1;
    else if (div_ovf)
      short_val = (op_in == OP_DIV) ? MIN_NEG : '0;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod   = {{DATA_WIDTH{1'b0}}, a_mag} * {{DATA_WIDTH{1'b0}}, b_mag};
    fast_signed = (sa ^ sb) ? -fast_prod : fast_prod;
    if (!is_div_in) begin
      short_path = 1'b1;
      short_val  = (op_in == OP_MUL) ? fast_signed[DATA_WIDTH-1:0]
                                     : fast_signed[2*DATA_WIDTH-1:DATA_WIDTH];
    end
`endif
  end

  // One iteration step; the multiplier/dividend shares the low half of acc_q
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    div_sh   = {acc_q, 1'b0};
    div_diff = div_sh[2*DATA_WIDTH:DATA_WIDTH] - {1'b0, mb_q};
    if (state_q == DIV) begin
      if (!div_diff[DATA_WIDTH])
        acc_nx = {div_diff[DATA_WIDTH-1:0], div_sh[DATA_WIDTH-1:1], 1'b1};
      else
        acc_nx = div_sh[2*DATA_WIDTH-1:0];
    end else begin
      acc_nx = {mul_sum, acc_q[DATA_WIDTH-1:1]};
    end
    last_iter  = (cnt_q == 5'd31);
    mul_signed = neg_q ? -acc_nx : acc_nx;
    quo_signed = neg_q ? -acc_nx[DATA_WIDTH-1:0] : acc_nx[DATA_WIDTH-1:0];
    rem_signed = rneg_q ? -acc_nx[2*DATA_WIDTH-1:DATA_WIDTH] : acc_nx[2*DATA_WIDTH-1:DATA_WIDTH];
    if (state_q == DIV)
      final_val = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? quo_signed : rem_signed;
    else
      final_val = (op_q == OP_MUL) ? mul_signed[DATA_WIDTH-1:0]
                                   : mul_signed[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (e_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept)
            state_d = short_path ? DONE : (is_div_in ? DIV : MUL);
          else
            state_d = IDLE;
        end
        MUL, DIV: if (last_iter) state_d = DONE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= OP_MUL;
      ma_q      <= '0;
      mb_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      md_result <= '0;
      md_rd     <= '0;
    end else if (accept) begin
      op_q   <= op_in;
      ma_q   <= a_mag;
      mb_q   <= b_mag;
      neg_q  <= sa ^ sb;
      rneg_q <= sa;
      acc_q  <= {{DATA_WIDTH{1'b0}}, (is_div_in ? a_mag : b_mag)};
      cnt_q  <= '0;
      rd_q   <= e_rd;
      if (short_path) begin
        md_result <= short_val;
        md_rd     <= e_rd;
      end
    end else if (((state_q == MUL) || (state_q == DIV)) && !e_flush) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 5'd1;
      if (last_iter) begin
        md_result <= final_val;
        md_rd     <= rd_q;
      end
    end
  end

  assign md_busy  = (state_q == MUL) || (state_q == DIV);
  assign md_done  = (state_q == DONE);
  assign md_stall = !rst && (md_busy || (e_start && ((state_q == IDLE) || (state_q == DONE)) && !e_flush));

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed RV32M corner cases plus random operations
// checked against an arithmetic reference model.
module tb_execute_muldiv;
  logic        clk = 1'b0;
  logic        rst;
  logic        e_start;
  logic [2:0]  e_mdop;
  logic [31:0] e_rd1, e_rd2;
  logic [4:0]  e_rd;
  logic        e_flush;
  logic        md_stall, md_busy, md_done;
  logic [31:0] md_result;
  logic [4:0]  md_rd;

  int total = 0;
  int bad   = 0;

  execute_muldiv #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .e_start(e_start), .e_mdop(e_mdop),
    .e_rd1(e_rd1), .e_rd2(e_rd2), .e_rd(e_rd), .e_flush(e_flush),
    .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done),
    .md_result(md_result), .md_rd(md_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, p;
    logic signed [31:0] sa, sb;
    logic        [63:0] up;
    sa = a; sb = b;
    sa64 = sa; sb64 = sb;
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * $signed({32'd0, b}); return p[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!op[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit now, input bit poke, input bit post);
    int lat;
    logic [31:0] exp;
    exp = ref_result(op, a, b);
    lat = ref_latency(op, a, b);
    if (!now) @(negedge clk);
    e_start = 1'b1; e_mdop = op; e_rd1 = a; e_rd2 = b; e_rd = rd;
    #1 chk("stall_on_start", 32'(md_stall), 32'd1);
    @(posedge clk);
    #1 e_start = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (poke && c == 3) begin
        e_start = 1'b1; e_rd1 = $urandom; e_rd2 = $urandom; e_rd = 5'($urandom);
        #1 chk("stall_while_busy", 32'(md_stall), 32'd1);
      end
      if (poke && c == 4) e_start = 1'b0;
      if (c < lat) begin
        chk("done_early", 32'(md_done), 32'd0);
        chk("busy_iter", 32'(md_busy), 32'd1);
      end else begin
        chk("done_at_latency", 32'(md_done), 32'd1);
        chk("busy_in_done", 32'(md_busy), 32'd0);
        chk("result", md_result, exp);
        chk("rd_tag", 32'(md_rd), 32'(rd));
      end
    end
    if (post) begin
      @(negedge clk);
      chk("done_one_cycle", 32'(md_done), 32'd0);
      chk("result_hold", md_result, exp);
      chk("rd_hold", 32'(md_rd), 32'(rd));
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1; e_start = 1'b0; e_mdop = '0; e_rd1 = '0; e_rd2 = '0; e_rd = '0; e_flush = 1'b0;
    #12;
    e_start = 1'b1;
    #1;
    chk("rst_busy", 32'(md_busy), 32'd0);
    chk("rst_done", 32'(md_done), 32'd0);
    chk("rst_result", md_result, 32'd0);
    chk("rst_rd", 32'(md_rd), 32'd0);
    chk("rst_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; e_start = 1'b0;

    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0, 0, 1);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0, 0, 1);
    do_op(3'd5, 32'd100, 32'd0, 5'd5, 0, 0, 1);
    do_op(3'd7, 32'd100, 32'd0, 5'd6, 0, 0, 1);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0, 0, 1);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0, 0, 1);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd9, 0, 0, 1);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 0, 0, 1);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 5'd11, 0, 0, 1);

    // Flush mid-divide: no result pulse afterwards
    @(negedge clk);
    e_start = 1'b1; e_mdop = 3'd5; e_rd1 = 32'd1000; e_rd2 = 32'd7; e_rd = 5'd12;
    @(posedge clk);
    #1 e_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush_busy_before", 32'(md_busy), 32'd1);
    e_flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_after", 32'(md_busy), 32'd0);
    chk("flush_stall_after", 32'(md_stall), 32'd0);
    chk("flush_done_after", 32'(md_done), 32'd0);
    e_flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (md_done) seen = 1'b1;
    end
    chk("flush_no_done", 32'(seen), 32'd0);

    // Flush wins over simultaneous start
    e_start = 1'b1; e_flush = 1'b1; e_mdop = 3'd0; e_rd1 = 32'd3; e_rd2 = 32'd4;
    #1 chk("flush_start_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    e_start = 1'b0; e_flush = 1'b0;
    chk("flush_start_busy", 32'(md_busy), 32'd0);
    chk("flush_start_done", 32'(md_done), 32'd0);

    // Reset in the middle of MULHU
    @(negedge clk);
    e_start = 1'b1; e_mdop = 3'd3; e_rd1 = 32'hDEAD_BEEF; e_rd2 = 32'h1234_5678; e_rd = 5'd13;
    @(posedge clk);
    #1 e_start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; e_start = 1'b1;
    #1;
    chk("midrst_busy", 32'(md_busy), 32'd0);
    chk("midrst_done", 32'(md_done), 32'd0);
    chk("midrst_result", md_result, 32'd0);
    chk("midrst_rd", 32'(md_rd), 32'd0);
    chk("midrst_stall", 32'(md_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0; e_start = 1'b0;

    // Back-to-back: MUL accepted in the DONE cycle of a bypassed divide
    do_op(3'd5, 32'd100, 32'd0, 5'd14, 0, 0, 0);
    do_op(3'd0, 32'd6, 32'd7, 5'd15, 1, 0, 1);

    for (int n = 0; n < 24; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int unsigned sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 300));
      do_op(op, a, b, 5'($urandom), 0, 1, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/execute_muldiv.md
EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, operand/result width (only 32 is supported).
REQ-002 SHALL provide clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL provide rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide e_start  input  1  execute-stage request to begin an M-extension operation.
REQ-005 SHALL provide e_mdop  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-006 SHALL provide e_rd1, e_rd2  input  DATA_WIDTH each  forwarded source operands a, b.
REQ-007 SHALL provide e_rd  input  5  destination register tag.
REQ-008 SHALL provide e_flush  input  1  abort the in-flight operation.
REQ-009 SHALL provide md_stall  output  1  freeze request to the hazard unit.
REQ-010 SHALL provide md_busy  output  1  operation in progress.
REQ-011 SHALL provide md_done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL provide md_result  output  DATA_WIDTH  result, valid while md_done=1.
REQ-013 SHALL provide md_rd  output  5  destination tag, valid while md_done=1.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 SHALL accept e_start only in IDLE or DONE and only when e_flush=0; acceptance latches op, a, b and e_rd.
REQ-016 SHALL treat signed operands as two's complement, iterate on magnitudes, and negate per RV32M sign rules.
REQ-017 SHALL, for iterative ops, run exactly 32 iteration cycles in MUL/DIV, then enter DONE; md_done is high on the 33rd cycle after the acceptance edge.
REQ-018 SHALL bypass iteration on divide-by-zero: DIV/DIVU quotient 0xFFFFFFFF, REM/REMU result equal to a; md_done is high on the cycle after acceptance.
REQ-019 SHALL bypass iteration on DIV overflow (a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0; done after 1 cycle.
REQ-020 SHALL keep md_done high for exactly one cycle in DONE; DONE then returns to IDLE, or moves to MUL/DIV when a new start is accepted that cycle (back-to-back).
REQ-021 SHALL drive md_busy=1 in MUL and DIV only.
REQ-022 SHALL drive md_stall = md_busy OR (e_start AND state in {IDLE,DONE} AND NOT e_flush), combinationally.
REQ-023 SHALL, on e_flush=1, enter IDLE at the next edge from any state and suppress md_done; flush wins over a simultaneous start.
REQ-024 SHALL ignore e_start while busy and hold the latched operands unchanged.
REQ-025 SHALL hold md_result and md_rd stable outside DONE at their last driven value; consumers use them only with md_done.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-operation, immediately enter IDLE and clear the iteration counter, all internal registers, md_busy, md_done, md_result and md_rd to 0.
REQ-027 SHALL report md_stall=0 while rst=1.

Configuration
REQ-028 SHALL support macro MULDIV_FAST_MUL_EN: when defined, MUL/MULH/MULHSU/MULHU use a single-cycle 64-bit product and reach DONE on the cycle after acceptance; when undefined, multiplies use the 32-cycle shift-add path of REQ-017. Division is always iterative.

Verification
REQ-029 SHALL pass: DIV a=0xFFFFFFF9 (-7), b=2 -> md_done at cycle 33, md_result=0xFFFFFFFD; REM gives 0xFFFFFFFF.
REQ-030 SHALL pass: DIVU a=100, b=0 -> md_done the cycle after start, md_result=0xFFFFFFFF; REMU gives 100.
REQ-031 SHALL pass: DIV a=0x80000000, b=0xFFFFFFFF -> md_result=0x80000000 after 1 cycle; REM gives 0.
REQ-032 SHALL pass: MULH a=0x80000000, b=0x80000000 -> md_result=0x40000000; cycle 33 without MULDIV_FAST_MUL_EN, cycle 1 with it.
REQ-033 SHALL pass: DIVU 1000/7 started, e_flush at cycle 10 -> IDLE next edge, no md_done pulse, md_stall=0.
REQ-034 SHALL pass: rst asserted at cycle 5 of MULHU -> outputs 0 immediately; then a back-to-back MUL 6x7 started in DONE -> 42.
